// File: rtl/div_unit_pkg.sv
// Shared defines for the multi-cycle divider: FSM encodings, handshake levels,
// ALU opcodes for DIV/DIVU and the EX stall-request bit position.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    // Bit of the stall-request vector driven by EX while a division is in flight.
    localparam int STALL_EX_IDX = 3;

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 iteration: trial-subtract the divisor from the upper
// partial remainder and produce the next upper field plus one quotient bit.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   upper_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] upper_o,
    output logic             quot_bit_o
);

    // Two guard bits: upper_i may reach 2*divisor-1, which needs WIDTH+1 bits unsigned.
    logic signed [WIDTH+1:0] diff;

    assign diff       = $signed({1'b0, upper_i}) - $signed({2'b00, divisor_i});
    assign quot_bit_o = ~diff[WIDTH+1];
    assign upper_o    = quot_bit_o ? diff[WIDTH-1:0] : upper_i[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned divider for DIV/DIVU; result is {remainder, quotient}.
// Define DIV_FASTPATH_EN to finish in one iteration slot when |dividend| < |divisor|.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    div_state_e         state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH:0]   work;
    logic [WIDTH-1:0]   divisor_mag;
    logic               neg_quot;
    logic               neg_rem;

    logic [WIDTH-1:0]   dvd_mag;
    logic [WIDTH-1:0]   dvs_mag;
    logic [WIDTH-1:0]   upper_next;
    logic               quot_bit;

    function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] x,
                                                     input logic en);
        return en ? (~x + WIDTH'(1)) : x;
    endfunction

    // The most negative value negates to itself and is then read as unsigned 2^(WIDTH-1).
    assign dvd_mag = cond_negate(opdata1_i, signed_div_i & opdata1_i[WIDTH-1]);
    assign dvs_mag = cond_negate(opdata2_i, signed_div_i & opdata2_i[WIDTH-1]);

    div_step #(.WIDTH(WIDTH)) u_step (
        .upper_i    (work[2*WIDTH:WIDTH]),
        .divisor_i  (divisor_mag),
        .upper_o    (upper_next),
        .quot_bit_o (quot_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DivFree;
            cnt      <= '0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
        end else begin
            case (state)
                DivFree: begin
                    ready_o  <= DivResultNotReady;
                    result_o <= '0;
                    if (start_i == DivStart && !annul_i) begin
                        neg_quot    <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_rem     <= signed_div_i & opdata1_i[WIDTH-1];
                        divisor_mag <= dvs_mag;
                        if (opdata2_i == '0) begin
                            state <= DivByZero;
`ifdef DIV_FASTPATH_EN
                        end else if (dvd_mag < dvs_mag) begin
                            // Preload the finished form (remainder = |dividend|, quotient = 0)
                            // so the next edge takes the normal sign-fixup exit.
                            work  <= {dvd_mag, {(WIDTH+1){1'b0}}};
                            cnt   <= CNT_W'(WIDTH);
                            state <= DivOn;
`endif
                        end else begin
                            work  <= {{WIDTH{1'b0}}, dvd_mag, 1'b0};
                            cnt   <= '0;
                            state <= DivOn;
                        end
                    end
                end
                DivByZero: begin
                    if (annul_i) begin
                        state <= DivFree;
                    end else begin
                        result_o <= '0;
                        ready_o  <= DivResultReady;
                        state    <= DivEnd;
                    end
                end
                DivOn: begin
                    if (annul_i) begin
                        result_o <= '0;
                        ready_o  <= DivResultNotReady;
                        state    <= DivFree;
                    end else if (cnt == CNT_W'(WIDTH)) begin
                        result_o <= {cond_negate(work[2*WIDTH:WIDTH+1], neg_rem),
                                     cond_negate(work[WIDTH-1:0], neg_quot)};
                        ready_o  <= DivResultReady;
                        state    <= DivEnd;
                    end else begin
                        work <= {upper_next, work[WIDTH-1:0], quot_bit};
                        cnt  <= cnt + CNT_W'(1);
                    end
                end
                DivEnd: begin
                    if (start_i == DivStop) begin
                        result_o <= '0;
                        ready_o  <= DivResultNotReady;
                        state    <= DivFree;
                    end
                end
                default: state <= DivFree;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table, hand-written corner sequences
// and randomized operations against an arithmetic reference model.
module tb_div_unit;

    localparam int WIDTH = 32;
`ifdef DIV_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        bit          sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Reference: 64-bit integer division truncates toward zero and the remainder
    // follows the dividend, which is exactly DIV/DIVU semantics without overflow.
    function automatic logic [63:0] ref_div(input bit sg, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int ref_lat(input bit sg, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb;
        if (b == 32'd0) return 1;
        ma = (sg && a[31]) ? -a : a;
        mb = (sg && b[31]) ? -b : b;
        if (FAST && ma < mb) return 1;
        return 33;
    endfunction

    // Caller has start high with operands set; the next edge is the accept edge.
    // Scrambles the operand inputs after accept, then counts edges until ready.
    task automatic wait_ready(output int lat, output logic [63:0] res);
        @(posedge clk); #1;
        op1        = $urandom;
        op2        = $urandom;
        signed_div = ~signed_div;
        lat = 0;
        while (!ready && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
    endtask

    task automatic finish_op(input string name, input logic [63:0] exp, input int exp_lat,
                             input int lat, input logic [63:0] res);
        check({name, "_lat"}, 64'(lat), 64'(exp_lat));
        check({name, "_res"}, res, exp);
        repeat (2) begin
            @(posedge clk); #1;
            check({name, "_hold_rdy"}, {63'd0, ready}, 64'd1);
            check({name, "_hold_res"}, result, exp);
        end
        start = 1'b0;
        @(posedge clk); #1;
        check({name, "_drop_rdy"}, {63'd0, ready}, 64'd0);
        check({name, "_drop_res"}, result, 64'd0);
    endtask

    task automatic run_op(input string name, input bit sg, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
        int          lat;
        logic [63:0] res;
        signed_div = sg;
        op1        = a;
        op2        = b;
        start      = 1'b1;
        wait_ready(lat, res);
        finish_op(name, exp, exp_lat, lat, res);
    endtask

    initial begin
        int          lat;
        logic [63:0] res;
        bit          saw_ready;
        logic [31:0] ra, rb;
        bit          rs;

        vecs[0] = '{1'b0, 32'd100,       32'd7,        {32'd2, 32'd14},                 33};
        vecs[1] = '{1'b1, 32'hFFFFFF9C,  32'd7,        {32'hFFFFFFFE, 32'hFFFFFFF2},    33};
        vecs[2] = '{1'b1, 32'h80000000,  32'hFFFFFFFF, {32'd0, 32'h80000000},           33};
        vecs[3] = '{1'b0, 32'h00001234,  32'd0,        64'd0,                           1};
        vecs[4] = '{1'b0, 32'd15,        32'd4,        {32'd3, 32'd3},                  33};
        vecs[5] = '{1'b0, 32'd5,         32'd9,        {32'd5, 32'd0},                  FAST ? 1 : 33};
        vecs[6] = '{1'b1, 32'd7,         32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD},           33};
        vecs[7] = '{1'b0, 32'hFFFFFFFF,  32'd1,        {32'd0, 32'hFFFFFFFF},           33};
        vecs[8] = '{1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE, {32'hFFFFFFFF, 32'd3},           33};
        vecs[9] = '{1'b1, 32'hFFFFFFFB,  32'd9,        {32'hFFFFFFFB, 32'd0},           FAST ? 1 : 33};

        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rdy", {63'd0, ready}, 64'd0);
        check("reset_res", result, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

        // Flush in the middle of an iteration run; the operation must vanish.
        signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #1;
        annul = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        annul = 1'b0;
        check("annul_rdy", {63'd0, ready}, 64'd0);
        saw_ready = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready) saw_ready = 1'b1;
        end
        check("annul_never_ready", {63'd0, saw_ready}, 64'd0);
        run_op("after_annul", 1'b0, 32'd15, 32'd4, {32'd3, 32'd3}, 33);

        // Annul held in the idle state must block acceptance.
        signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1; annul = 1'b1;
        saw_ready = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready) saw_ready = 1'b1;
        end
        check("annul_blocks", {63'd0, saw_ready}, 64'd0);
        annul = 1'b0;
        wait_ready(lat, res);
        finish_op("annul_release", {32'd2, 32'd14}, 33, lat, res);

        // Reset partway through, with start held across and after the reset.
        signed_div = 1'b1; op1 = 32'hFFFFFF9C; op2 = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_rdy", {63'd0, ready}, 64'd0);
        check("midrst_res", result, 64'd0);
        signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7;
        rst = 1'b0;
        wait_ready(lat, res);
        finish_op("post_rst", {32'd2, 32'd14}, 33, lat, res);

        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: begin ra = $urandom; rb = 32'd0; end
                1: begin ra = $urandom_range(0, 50); rb = $urandom; end
                2: begin ra = $urandom; rb = $urandom_range(1, 20); end
                3: begin ra = $urandom; rb = 32'hFFFFFFFF - $urandom_range(0, 5); end
                default: begin ra = $urandom; rb = $urandom; end
            endcase
            run_op($sformatf("rnd%0d", i), rs, ra, rb, ref_div(rs, ra, rb), ref_lat(rs, ra, rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit signed/unsigned integer divider for DIV/DIVU. Sits beside the execute stage.
- EX launches an operation with a start pulse and holds the pipeline stalled until ready_o rises.
- EX then forwards the 64-bit result into the HI/LO write path through EX/MEM: HI = remainder, LO = quotient.
- Restoring radix-2 algorithm, one quotient bit per clock.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- signed_div_i  input  1  1 = DIV (signed), 0 = DIVU.
- opdata1_i  input  WIDTH  dividend.
- opdata2_i  input  WIDTH  divisor.
- start_i  input  1  request; held high by EX until ready_o is seen.
- annul_i  input  1  abort the current operation (flush).
- result_o  output  2*WIDTH  {remainder, quotient}.
- ready_o  output  1  result valid.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset: state=DivFree, cnt=0, result_o=0, ready_o=0. A reset mid-operation discards all work, and the next cycle is DivFree.

FSM states are DivFree, DivByZero, DivOn and DivEnd. Edges are numbered from E0, the edge that accepts start.
- DivFree: ready_o=0, result_o=0.
  - start_i=1 and annul_i=0 at E0, divisor==0: go to DivByZero.
  - start_i=1 and annul_i=0 at E0, divisor!=0: latch |dividend| and |divisor| (when signed_div_i=1 and the MSB is set, two's-complement negate), latch the sign bits, set the working register to {WIDTH'b0, |dividend|, 1'b0}, cnt=0, go to DivOn.
  - Otherwise stay in DivFree.
- DivByZero: at the next edge go to DivEnd with result=0 (quotient 0, remainder 0). No exception is raised.
- DivOn, one iteration per edge while annul_i=0:
  - Compute diff = upper(WIDTH+1 bits) − divisor.
  - diff < 0: shift left, inserting 0.
  - diff >= 0: replace the upper bits with diff, then shift left, inserting 1.
  - cnt increments each iteration. Iterations run at E1..E32.
  - At E33 (cnt==WIDTH), apply signs and go to DivEnd:
    - Signed quotient is negated when dividend sign ^ divisor sign.
    - Signed remainder takes the sign of the dividend.
    - Latch result_o and set ready_o=1.
  - Latency: ready_o is first high in the cycle after E33, which is 33 cycles after accept. Divide-by-zero gives ready after E1.
- DivEnd: ready_o=1 and result_o is stable.
  - When start_i==0, go to DivFree at the next edge, clearing ready_o and result_o.
  - While start_i stays 1, hold DivEnd. A new division requires start_i to drop for at least one cycle.
- annul_i=1 in DivOn or DivByZero: go to DivFree at the next edge, ready_o=0, no result. annul_i in DivFree blocks accept.
- Operands are sampled only at E0. Input changes afterwards are ignored.
- Edge cases:
  - Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0 (wraps, no trap).
  - Negating 0x80000000 yields 0x80000000, treated as unsigned 2^31 in the datapath.

Optional Feature:
- Macro: DIV_FASTPATH_EN.
- Defined: at E0, if |dividend| < |divisor| (unsigned compare of the magnitudes), skip DivOn. Go directly to DivEnd with quotient=0 and remainder=original dividend (sign preserved), so ready_o is high after E1. Dividend==0 with a nonzero divisor is also fast-pathed.
- Not defined: every nonzero-divisor operation takes the full 33-cycle path. Results are identical in both builds; only latency differs.

Decomposition:
- Shared defines file gets:
  - state encodings DivFree/DivByZero/DivOn/DivEnd (2-bit);
  - DivResultReady/DivResultNotReady;
  - DivStart/DivStop;
  - the new AluOp codes for DIV/DIVU (EXE_DIV_OP, EXE_DIVU_OP);
  - stall-request bit index for EX.
- Sub-module div_step: combinational single iteration (upper bits, divisor → next working register plus quotient bit). It is reused as-is if the radix is later doubled.

Test Plan:
- Unsigned 100 / 7, start held → ready_o after 33 cycles, result_o = {32'd2, 32'd14}; ready holds until start drops, then 0 next cycle.
- Signed −100 (0xFFFFFF9C) / 7 → quotient 0xFFFFFFF2 (−14), remainder 0xFFFFFFFE (−2); signed 0x80000000 / 0xFFFFFFFF → {0, 0x80000000}.
- Divisor 0 (DIVU 0x1234 / 0) → DivByZero, ready after E1, result_o = 0.
- annul_i pulsed at cycle 10 of DivOn → ready_o never rises, state DivFree next cycle; a new start afterwards (15/4 unsigned) → {3, 3} after 33 cycles.
- rst asserted at cycle 20 of an operation → next cycle result_o=0, ready_o=0, DivFree; start held continuously from reset release → accepted on the first edge.
- DIV_FASTPATH_EN defined, DIVU 5 / 9 → ready after E1, result {5, 0}. Undefined → same result after 33 cycles.
